// File: rtl/scan_pkg.sv
// Shared types and constants for the six-digit HH:MM:SS scan controller.
package scan_pkg;

  localparam int NUM_DIGITS = 6;

  // Digit index 0..5: segundo1, segundo2, minuto1, minuto2, hora1, hora2
  typedef logic [2:0] digit_idx_t;

  localparam logic [5:0] ANODE_OFF = 6'b111111;
  localparam digit_idx_t IDX_HORA2 = 3'd5;
  localparam digit_idx_t IDX_LAST  = digit_idx_t'(NUM_DIGITS - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Active-low one-hot anode pattern for a digit index
  function automatic logic [5:0] anode_for(input digit_idx_t idx);
    return ~(6'b000001 << idx);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler: counts 0..TICK_DIV-1 while run is high, clears to 0
// synchronously whenever run is low. With SCAN_BLANK_EN defined it also
// reports whether the upcoming cycle falls inside the slot's dead-time window.
module scan_tick_gen #(
  parameter int TICK_DIV     = 100000
`ifdef SCAN_BLANK_EN
  ,
  parameter int BLANK_CYCLES = 1000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic slot_last
`ifdef SCAN_BLANK_EN
  ,
  output logic in_blank
`endif
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign slot_last = (cnt_reg == CNT_LAST);

  // Next count: advance while running, wrap at slot end, clear when stopped
  always_comb begin
    cnt_next = '0;
    if (run && !slot_last) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

`ifdef SCAN_BLANK_EN
  // Looks at the next count so the top can register blank/anode in step
  assign in_blank = (cnt_next < CNT_W'(BLANK_CYCLES));
`endif

  // Prescaler register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Six-digit seven-segment scan controller with frame-coherent digit snapshot.
// Optional feature: define SCAN_BLANK_EN to insert BLANK_CYCLES of anode
// dead time at the start of every slot (anti-ghosting).
module display_scan_ctrl
  import scan_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       lz_en,
  input  logic [3:0] segundo1,
  input  logic [3:0] segundo2,
  input  logic [3:0] minuto1,
  input  logic [3:0] minuto2,
  input  logic [3:0] hora1,
  input  logic [3:0] hora2,
  output logic [2:0] digit_sel,
  output logic [3:0] digit_val,
  output logic [5:0] anode_n,
  output logic       blank,
  output logic       frame_start
);

  state_t     state_reg, state_next;
  digit_idx_t idx_reg, idx_next;
  logic [23:0] snap_reg, snap_next;
  logic       load;
  logic       run;
  logic       slot_last;
  logic       window;

  logic [2:0] digit_sel_reg, digit_sel_next;
  logic [3:0] digit_val_reg, digit_val_next;
  logic [5:0] anode_reg, anode_next;
  logic       blank_reg, blank_next;
  logic       frame_start_reg, frame_start_next;

  // Prescaler only counts while the scan stays enabled in RUN
  assign run = (state_reg == RUN) && en;

`ifdef SCAN_BLANK_EN
  logic in_blank;

  scan_tick_gen #(
    .TICK_DIV    (TICK_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .slot_last(slot_last),
    .in_blank (in_blank)
  );

  assign window = in_blank;
`else
  scan_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .slot_last(slot_last)
  );

  assign window = 1'b0;
`endif

  // Next state, next index, snapshot load and next registered outputs
  always_comb begin
    state_next       = state_reg;
    idx_next         = '0;
    load             = 1'b0;
    snap_next        = snap_reg;
    digit_sel_next   = '0;
    digit_val_next   = '0;
    anode_next       = ANODE_OFF;
    blank_next       = 1'b0;
    frame_start_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (en) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_next = IDLE;
        end else if (slot_last) begin
          if (idx_reg == IDX_LAST) begin
            load = 1'b1;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          idx_next = idx_reg;
        end
      end
      default: state_next = IDLE;
    endcase

    // A new frame (index 0 slot start) always captures all six digits
    if (load) begin
      snap_next = {hora2, hora1, minuto2, minuto1, segundo2, segundo1};
    end

    digit_sel_next   = idx_next;
    digit_val_next   = snap_next[{idx_next, 2'b00} +: 4];
    frame_start_next = load;

    if (state_next == RUN) begin
      if (window) begin
        blank_next = 1'b1;
      end else if (!(lz_en && (idx_next == IDX_HORA2) && (snap_next[23:20] == 4'd0))) begin
        anode_next = anode_for(idx_next);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Index, snapshot and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg         <= '0;
      snap_reg        <= '0;
      digit_sel_reg   <= '0;
      digit_val_reg   <= '0;
      anode_reg       <= ANODE_OFF;
      blank_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      idx_reg         <= idx_next;
      snap_reg        <= snap_next;
      digit_sel_reg   <= digit_sel_next;
      digit_val_reg   <= digit_val_next;
      anode_reg       <= anode_next;
      blank_reg       <= blank_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign digit_sel   = digit_sel_reg;
  assign digit_val   = digit_val_reg;
  assign anode_n     = anode_reg;
  assign blank       = blank_reg;
  assign frame_start = frame_start_reg;

endmodule
